// File: rtl/mips_muldiv_pkg.sv
// Shared types for the iterative MIPS multiply/divide unit.
// Latency: none (types and helpers only); backpressure: not applicable.
package mips_muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } muldiv_state_t;

    function automatic logic op_is_signed(input muldiv_op_t op);
        return (op == MULT) || (op == DIV);
    endfunction

    function automatic logic op_is_div(input muldiv_op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/mips_muldiv_if.sv
// Core <-> mul/div unit handshake and HI/LO result bus.
// Latency: wires only; backpressure: start_ready drops while the unit is busy.
interface mips_muldiv_if #(
    parameter int WIDTH = mips_muldiv_pkg::DEFAULT_WIDTH
) ();
    import mips_muldiv_pkg::*;

    logic             clock_enable;
    logic             start_valid;
    logic             start_ready;
    muldiv_op_t       op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output clock_enable, start_valid, op, op_a, op_b,
        input  start_ready, busy, done, hi, lo
    );

    modport slave (
        input  clock_enable, start_valid, op, op_a, op_b,
        output start_ready, busy, done, hi, lo
    );

endinterface

// File: rtl/mips_muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide step.
// Latency: combinational; backpressure: none.
module mips_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               mode_div_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic               q_bit_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_next;

    always_comb begin
        sum      = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, (acc_i[0] ? opnd_i : {WIDTH{1'b0}})};
        // Divide: acc is {remainder, remaining dividend bits}; the quotient fills in from the LSB.
        rem_sh   = acc_i[2*WIDTH-1:WIDTH-1];
        q_bit_o  = 1'b0;
        rem_next = rem_sh[WIDTH-1:0];
        acc_o    = {sum, acc_i[WIDTH-1:1]};
        if (mode_div_i) begin
            q_bit_o = (rem_sh >= {1'b0, opnd_i});
            if (q_bit_o) begin
                rem_next = WIDTH'(rem_sh - {1'b0, opnd_i});
            end
            acc_o = {rem_next, acc_i[WIDTH-2:0], q_bit_o};
        end
    end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO, owner of the HI/LO registers.
// Latency: WIDTH+1 enabled cycles from accept to result; backpressure: start_ready low while busy.
module mips_muldiv_unit #(
    parameter int WIDTH = mips_muldiv_pkg::DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    mips_muldiv_if.slave bus
);
    import mips_muldiv_pkg::*;

    localparam int CNT_W = $clog2(WIDTH);

    muldiv_state_t      state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   raw_a_q;
    logic               div_q;
    logic               dz_q;
    logic               sa_q;
    logic               sb_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    logic               sa_d;
    logic               sb_d;
    logic [WIDTH-1:0]   mag_a_d;
    logic [WIDTH-1:0]   mag_b_d;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic               q_bit_unused;

    assign bus.start_ready = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

    mips_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode_div_i (div_q),
        .acc_i      (acc_q),
        .opnd_i     (opnd_q),
        .acc_o      (acc_d),
        .q_bit_o    (q_bit_unused)
    );

    always_comb begin
        sa_d    = op_is_signed(bus.op) && bus.op_a[WIDTH-1];
        sb_d    = op_is_signed(bus.op) && bus.op_b[WIDTH-1];
        mag_a_d = sa_d ? (~bus.op_a + 1'b1) : bus.op_a;
        mag_b_d = sb_d ? (~bus.op_b + 1'b1) : bus.op_b;
    end

    // Sign fixup; unsigned ops never record sign bits, so they pass straight through.
    always_comb begin
        prod_neg = ~acc_q + 1'b1;
        quot     = acc_q[WIDTH-1:0];
        rem      = acc_q[2*WIDTH-1:WIDTH];
        {hi_d, lo_d} = (sa_q ^ sb_q) ? prod_neg : acc_q;
        if (div_q) begin
            if (dz_q) begin
                lo_d = {WIDTH{1'b1}};
                hi_d = raw_a_q;
            end else begin
                lo_d = (sa_q ^ sb_q) ? (~quot + 1'b1) : quot;
                hi_d = sa_q ? (~rem + 1'b1) : rem;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            raw_a_q <= '0;
            div_q   <= 1'b0;
            dz_q    <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else if (bus.clock_enable) begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start_valid) begin
                        case (bus.op)
                            MTHI: hi_q <= bus.op_a;
                            MTLO: lo_q <= bus.op_a;
                            MULT, MULTU, DIV, DIVU: begin
                                state_q <= RUN;
                                cnt_q   <= CNT_W'(WIDTH - 1);
                                div_q   <= op_is_div(bus.op);
                                sa_q    <= sa_d;
                                sb_q    <= sb_d;
                                raw_a_q <= bus.op_a;
                                dz_q    <= (bus.op_b == '0);
                                if (op_is_div(bus.op)) begin
                                    acc_q  <= {{WIDTH{1'b0}}, mag_a_d};
                                    opnd_q <= mag_b_d;
                                end else begin
                                    acc_q  <= {{WIDTH{1'b0}}, mag_b_d};
                                    opnd_q <= mag_a_d;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    if (cnt_q == '0) begin
                        state_q <= FINISH;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                FINISH: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit: vector table plus handshake, enable and reset sequences.
module tb_mips_muldiv_unit;
    import mips_muldiv_pkg::*;

    localparam int W = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mips_muldiv_if #(.WIDTH(W)) bus ();

    mips_muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        muldiv_op_t   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input muldiv_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
        chk("ready_before_issue", {31'd0, bus.start_ready}, 32'd1);
        bus.op          = op;
        bus.op_a        = a;
        bus.op_b        = b;
        bus.start_valid = 1'b1;
        tick();
        bus.start_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (bus.done !== 1'b1 && lat < budget) begin
            if (bus.busy) bcnt++;
            tick();
            lat++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int lat;
        int bcnt;
        int lat2;
        int rdy_bad;
        int seen;

        vecs[0] = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2] = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4] = '{DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF};
        vecs[5] = '{DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[6] = '{DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        vecs[7] = '{MULT,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2};
        vecs[8] = '{DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[9] = '{MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

        bus.clock_enable = 1'b1;
        bus.start_valid  = 1'b0;
        bus.op           = MULT;
        bus.op_a         = '0;
        bus.op_b         = '0;

        #12;
        chk("rst_hi",    bus.hi, 32'd0);
        chk("rst_lo",    bus.lo, 32'd0);
        chk("rst_busy",  {31'd0, bus.busy}, 32'd0);
        chk("rst_done",  {31'd0, bus.done}, 32'd0);
        chk("rst_ready", {31'd0, bus.start_ready}, 32'd1);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(60, lat, bcnt);
            chk($sformatf("v%0d_hi", i), bus.hi, vecs[i].hi);
            chk($sformatf("v%0d_lo", i), bus.lo, vecs[i].lo);
            chk($sformatf("v%0d_latency", i), W'(lat), 32'd33);
            chk($sformatf("v%0d_busy_cycles", i), W'(bcnt), 32'd33);
            tick();
            chk($sformatf("v%0d_done_pulse", i), {31'd0, bus.done}, 32'd0);
        end

        // MTHI then MTLO on consecutive edges.
        bus.op          = MTHI;
        bus.op_a        = 32'h12345678;
        bus.start_valid = 1'b1;
        tick();
        chk("mthi_hi",   bus.hi, 32'h12345678);
        chk("mthi_busy", {31'd0, bus.busy}, 32'd0);
        chk("mthi_done", {31'd0, bus.done}, 32'd0);
        bus.op   = MTLO;
        bus.op_a = 32'h9ABCDEF0;
        tick();
        bus.start_valid = 1'b0;
        chk("mtlo_lo",   bus.lo, 32'h9ABCDEF0);
        chk("mtlo_hi",   bus.hi, 32'h12345678);
        chk("mtlo_busy", {31'd0, bus.busy}, 32'd0);
        chk("mtlo_done", {31'd0, bus.done}, 32'd0);

        // Unused encoding is a no-op.
        bus.op          = muldiv_op_t'(3'd6);
        bus.op_a        = 32'hDEADBEEF;
        bus.start_valid = 1'b1;
        tick();
        bus.start_valid = 1'b0;
        chk("nop_busy", {31'd0, bus.busy}, 32'd0);
        chk("nop_hi",   bus.hi, 32'h12345678);
        chk("nop_lo",   bus.lo, 32'h9ABCDEF0);
        tick();
        chk("nop_done", {31'd0, bus.done}, 32'd0);

        // MULTU 6*7 with a second op held on start_valid throughout RUN.
        issue(MULTU, 32'd6, 32'd7);
        bus.op_a        = 32'd3;
        bus.op_b        = 32'd3;
        bus.start_valid = 1'b1;
        lat     = 0;
        rdy_bad = 0;
        while (bus.done !== 1'b1 && lat < 60) begin
            if (bus.start_ready) rdy_bad++;
            tick();
            lat++;
        end
        chk("b2b_latency",   W'(lat), 32'd33);
        chk("b2b_ready_low", W'(rdy_bad), 32'd0);
        chk("b2b_lo",        bus.lo, 32'd42);
        chk("b2b_hi",        bus.hi, 32'd0);
        tick();
        bus.start_valid = 1'b0;
        chk("b2b_second_busy", {31'd0, bus.busy}, 32'd1);
        chk("b2b_done_clear",  {31'd0, bus.done}, 32'd0);
        wait_done(60, lat, bcnt);
        chk("b2b_second_latency", W'(lat), 32'd33);
        chk("b2b_second_lo",      bus.lo, 32'd9);
        chk("b2b_second_hi",      bus.hi, 32'd0);
        tick();

        // DIVU 100/7 with five disabled cycles mid-RUN.
        issue(DIVU, 32'd100, 32'd7);
        repeat (10) tick();
        bus.clock_enable = 1'b0;
        repeat (5) tick();
        chk("ce_busy_hold", {31'd0, bus.busy}, 32'd1);
        chk("ce_done_hold", {31'd0, bus.done}, 32'd0);
        bus.clock_enable = 1'b1;
        wait_done(60, lat2, bcnt);
        chk("ce_latency", W'(15 + lat2), 32'd38);
        chk("ce_lo",      bus.lo, 32'd14);
        chk("ce_hi",      bus.hi, 32'd2);
        bus.clock_enable = 1'b0;
        tick();
        tick();
        chk("ce_done_sticky", {31'd0, bus.done}, 32'd1);
        bus.clock_enable = 1'b1;
        tick();
        chk("ce_done_cleared", {31'd0, bus.done}, 32'd0);

        // Asynchronous reset in the middle of a MULT.
        issue(MULT, 32'h00001234, 32'd5);
        repeat (10) tick();
        #2 reset = 1'b0;
        #1;
        chk("arst_hi",    bus.hi, 32'd0);
        chk("arst_lo",    bus.lo, 32'd0);
        chk("arst_busy",  {31'd0, bus.busy}, 32'd0);
        chk("arst_ready", {31'd0, bus.start_ready}, 32'd1);
        chk("arst_done",  {31'd0, bus.done}, 32'd0);
        #2 reset = 1'b1;
        seen = 0;
        repeat (40) begin
            tick();
            if (bus.done === 1'b1) seen++;
        end
        chk("arst_no_done", W'(seen), 32'd0);
        chk("arst_idle",    {31'd0, bus.busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit owning the HI/LO registers.
- Replaces the single-cycle ALU multiply/divide path and in-core HI/LO in the next-generation MIPS core.
- Radix-2 shift-add multiply and restoring divide, one bit per enabled cycle; start/ready/busy/done handshake so the core stalls MFHI/MFLO and further mul/div ops.
- Also executes MTHI/MTLO.

Parameters:
- WIDTH, 32, operand/HI/LO width; even, >=4.
- CNT_W, $clog2(WIDTH), iteration counter width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- clock_enable  in  1  when 0 all state, HI/LO and outputs hold.
- start_valid  in  1  core presents an op.
- start_ready  out  1  unit can accept an op (state IDLE).
- op  in  3  muldiv_op_t: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- op_a  in  WIDTH  rs value (dividend / multiplicand / MTHI-MTLO source).
- op_b  in  WIDTH  rt value (divisor / multiplier).
- busy  out  1  state != IDLE; core stalls MFHI/MFLO and mul/div ops.
- done  out  1  one-cycle pulse after a MULT/MULTU/DIV/DIVU result is written.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset=0, async): state=IDLE, hi=0, lo=0, done=0, counter=0, busy=0, start_ready=1. Reset mid-operation discards the op; no done pulse.
- Accept = start_valid && start_ready && clock_enable, sampled at rising edge E0.
- Every state transition and datapath step requires clock_enable=1; with clock_enable=0 nothing changes, including done, which stays high if already high.
- States:
  - IDLE -> RUN on an accepted mul/div op.
  - RUN -> FINISH when counter==0 on an enabled edge.
  - FINISH -> IDLE.
- MTHI/MTLO: at E0 hi (resp. lo) <= op_a; state stays IDLE; no done pulse.
- E0 (mul/div): latch the op; store |a|, |b| for signed ops (raw for unsigned); record sign bits; counter <= WIDTH-1.
- RUN: one iteration per enabled edge.
  - Multiply: 2*WIDTH accumulator, shift-add.
  - Divide: restoring step, remainder WIDTH+1 bits, quotient shifted in LSB-first.
  - Exactly WIDTH iterations, at edges E1..E_WIDTH.
- FINISH (edge E_WIDTH+1): apply sign fixup, write hi/lo, done <= 1 for the next cycle. Results are visible at E_WIDTH+1 (33 cycles after accept for WIDTH=32).
- done is cleared at the next enabled edge. A new op may be accepted while done=1 (back-to-back ops allowed).
- Multiply results: {hi,lo} = full 2*WIDTH product. MULT is signed two's complement: negate the product if sign_a^sign_b.
- Divide results: lo = quotient, hi = remainder.
  - DIV: quotient negated if sign_a^sign_b; remainder takes the sign of the dividend (truncating division).
  - Most-negative / -1 gives lo = most-negative value, hi = 0 (natural wrap of the magnitude path).
- Divide by zero (both DIV and DIVU): lo = all ones, hi = op_a as latched, unmodified; the sign fixup is bypassed. Latency is unchanged.
- start_valid while busy: ignored, start_ready=0, no state change. The core must hold the op until accepted.
- op_a/op_b may change after E0; the unit uses only the latched copies.
- Unused op encodings are accepted as a no-op: state stays IDLE, no done pulse.

Decomposition:
- Package mips_muldiv_pkg holds:
  - typedef enum logic[2:0] muldiv_op_t: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5.
  - typedef enum logic[1:0] muldiv_state_t: IDLE, RUN, FINISH.
  - The default WIDTH constant.
- One sub-module, mips_muldiv_step: combinational single iteration. Inputs: mode (mul/div), accumulator/remainder, operand. Outputs: next accumulator/remainder and quotient bit.
- FSM, counter, sign logic and HI/LO stay in the top module.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001; done high exactly 33 cycles after accept; busy high for 32 cycles, then one FINISH cycle.
- MULT a=0xFFFFFFFD(-3) b=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1. DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0. DIVU a=5 b=0 -> lo=0xFFFFFFFF hi=5. DIV a=0xFFFFFFF9 b=0 -> lo=0xFFFFFFFF hi=0xFFFFFFF9.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> hi/lo update the next edge, no done, busy stays 0. Then MULTU 6*7 while start_valid is re-asserted during RUN -> second op not accepted until done; lo=42, hi=0.
- clock_enable held 0 for 5 cycles mid-RUN during DIVU 100/7 -> done delayed by exactly 5 cycles; lo=14 hi=2.
- reset pulled low at iteration 10 of MULT -> hi=lo=0, busy=0, start_ready=1 immediately (async); no done pulse after release.
